// File: rtl/joy_pkg.sv
// Shared pad definitions: bit positions of the MXYZ SACB RLDU word plus the
// opposing-direction cleaner used by the conditioner.
package joy_pkg;

    localparam int JOY_W = 12;

    localparam int JOY_U = 0;
    localparam int JOY_D = 1;
    localparam int JOY_L = 2;
    localparam int JOY_R = 3;
    localparam int JOY_B = 4;
    localparam int JOY_C = 5;
    localparam int JOY_A = 6;
    localparam int JOY_S = 7;
    localparam int JOY_Z = 8;
    localparam int JOY_Y = 9;
    localparam int JOY_X = 10;
    localparam int JOY_M = 11;

    // Wide enough for DEB_TICKS / AF_HALF up to 15.
    localparam int CNT_W = 4;

    typedef logic [JOY_W-1:0] joy_word_t;

    // Positive-logic word in, opposing direction pairs cancelled out.
    function automatic joy_word_t socd_clean(input joy_word_t p);
        joy_word_t w;
        w = p;
        if (p[JOY_U] && p[JOY_D]) begin
            w[JOY_U] = 1'b0;
            w[JOY_D] = 1'b0;
        end
        if (p[JOY_L] && p[JOY_R]) begin
            w[JOY_L] = 1'b0;
            w[JOY_R] = 1'b0;
        end
        return w;
    endfunction

endpackage

// File: rtl/joy_debounce_bit.sv
// One debounced pad line: the stable level flips only after the raw level has
// disagreed with it on DEB_TICKS consecutive sample ticks.
module joy_debounce_bit
    import joy_pkg::*;
#(
    parameter int DEB_TICKS = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic tick,
    input  logic raw,
    output logic stable
);

    logic             s_q;
    logic             s_d;
    logic [CNT_W-1:0] c_q;
    logic [CNT_W-1:0] c_d;
    logic [CNT_W:0]   c_inc;

    always_comb begin
        s_d   = s_q;
        c_d   = c_q;
        c_inc = {1'b0, c_q} + (CNT_W+1)'(1);
        if (tick) begin
            if (raw == s_q) begin
                c_d = '0;
            end else if (c_inc == (CNT_W+1)'(DEB_TICKS)) begin
                s_d = raw;
                c_d = '0;
            end else begin
                c_d = c_inc[CNT_W-1:0];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            s_q <= 1'b1;
            c_q <= '0;
        end else begin
            s_q <= s_d;
            c_q <= c_d;
        end
    end

    assign stable = s_q;

endmodule

// File: rtl/joy_conditioner.sv
// Two-player pad conditioner: input register, per-bit debounce, SOCD cleaning,
// per-player autofire on B, registered positive-logic outputs and change strobe.
module joy_conditioner
    import joy_pkg::*;
#(
    parameter int DEB_TICKS = 4,
    parameter int AF_HALF   = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             line_tick,
    input  logic             frame_tick,
    input  logic [JOY_W-1:0] joy1_n,
    input  logic [JOY_W-1:0] joy2_n,
    input  logic [1:0]       af_en,
    output logic [JOY_W-1:0] joy1,
    output logic [JOY_W-1:0] joy2,
    output logic             chg
);

    joy_word_t raw_q    [2];
    joy_word_t raw_d    [2];
    joy_word_t stable_w [2];
    joy_word_t joy_q    [2];
    joy_word_t joy_d    [2];
    logic      chg_q;
    logic      chg_d;

    always_comb begin
        raw_d[0] = joy1_n;
        raw_d[1] = joy2_n;
    end

    // Raw resets to "all released" so nothing starts counting during reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            raw_q[0] <= '1;
            raw_q[1] <= '1;
        end else begin
            raw_q[0] <= raw_d[0];
            raw_q[1] <= raw_d[1];
        end
    end

    genvar gp;
    genvar gi;
    generate
        for (gp = 0; gp < 2; gp++) begin : g_player
            for (gi = 0; gi < JOY_W; gi++) begin : g_bit
                joy_debounce_bit #(
                    .DEB_TICKS (DEB_TICKS)
                ) u_deb (
                    .clk    (clk),
                    .reset  (reset),
                    .tick   (line_tick),
                    .raw    (raw_q[gp][gi]),
                    .stable (stable_w[gp][gi])
                );
            end

            joy_word_t        pressed;
            joy_word_t        clean;
            joy_word_t        joy_next;
            logic             ph_q;
            logic             ph_d;
            logic [CNT_W-1:0] ac_q;
            logic [CNT_W-1:0] ac_d;
            logic [CNT_W:0]   ac_inc;

            assign pressed = ~stable_w[gp];
            assign clean   = socd_clean(pressed);

            // Autofire keys off the debounced B from before this edge, so a
            // same-cycle debounce flip is only seen one cycle later.
            always_comb begin
                ph_d     = ph_q;
                ac_d     = ac_q;
                joy_next = clean;
                ac_inc   = {1'b0, ac_q} + (CNT_W+1)'(1);
                if (!af_en[gp] || !pressed[JOY_B]) begin
                    ph_d = 1'b1;
                    ac_d = '0;
                end else begin
                    joy_next[JOY_B] = ph_q;
                    if (frame_tick) begin
                        if (ac_inc == (CNT_W+1)'(AF_HALF)) begin
                            ph_d = ~ph_q;
                            ac_d = '0;
                        end else begin
                            ac_d = ac_inc[CNT_W-1:0];
                        end
                    end
                end
            end

            always_ff @(posedge clk) begin
                if (reset) begin
                    ph_q <= 1'b1;
                    ac_q <= '0;
                end else begin
                    ph_q <= ph_d;
                    ac_q <= ac_d;
                end
            end

            assign joy_d[gp] = joy_next;
        end
    endgenerate

    always_comb begin
        chg_d = (joy_d[0] != joy_q[0]) || (joy_d[1] != joy_q[1]);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            joy_q[0] <= '0;
            joy_q[1] <= '0;
            chg_q    <= 1'b0;
        end else begin
            joy_q[0] <= joy_d[0];
            joy_q[1] <= joy_d[1];
            chg_q    <= chg_d;
        end
    end

    assign joy1 = joy_q[0];
    assign joy2 = joy_q[1];
    assign chg  = chg_q;

endmodule
